// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-lite initiator.
// A user command is turned into one complete AXI4-lite read or write, and
// the slave's response is returned on the rsp_* interface.
// Optional watchdog: define AXIL_MASTER_TIMEOUT_EN to abort transactions
// that stall for C_TIMEOUT_CYCLES cycles in any AXI phase.
module axi_lite_master #(
  parameter int C_ADDR_WIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 255
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // user command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]             cmd_wdata,
  input  logic [3:0]              cmd_wstrb,
  // user response
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // AXI4-lite write address / data / response
  output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  // AXI4-lite read address / data
  output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [C_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_wstrb;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic [31:0]             r_rdata;
  logic [1:0]              r_resp;

  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_all;
  logic w_w_all;
  logic w_active;
  logic w_progress;
  logic w_tmo_fire;

  assign w_cmd_hs = cmd_valid && cmd_ready;
  assign w_aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_w_hs   = m_axi_wvalid && m_axi_wready;
  // AW and W complete independently; each is done once accepted now or earlier
  assign w_aw_all = r_aw_done || w_aw_hs;
  assign w_w_all  = r_w_done || w_w_hs;

  // States that wait on the slave (and are therefore guarded by the watchdog)
  assign w_active = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                    (r_state == S_RADDR) || (r_state == S_RDATA);

  // The current AXI phase completes this cycle
  assign w_progress = ((r_state == S_WRITE) && w_aw_all && w_w_all) ||
                      ((r_state == S_WRESP) && m_axi_bvalid) ||
                      ((r_state == S_RADDR) && m_axi_arready) ||
                      ((r_state == S_RDATA) && m_axi_rvalid);

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_timeout;

  // Watchdog fires on the C_TIMEOUT_CYCLES-th cycle spent in one phase,
  // unless that phase completes in the same cycle
  assign w_tmo_fire = w_active && !w_progress &&
                      (r_count == CNT_W'(C_TIMEOUT_CYCLES - 1));

  // Cycle counter: cleared on every state change, counts in waiting states
  always_ff @(posedge aclk) begin
    if (!aresetn || (w_state_next != r_state)) begin
      r_count <= '0;
    end else if (w_active) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Timeout flag: set on abort, held until the next command is accepted
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_timeout <= 1'b0;
    end else if (w_cmd_hs) begin
      r_timeout <= 1'b0;
    end else if (w_tmo_fire) begin
      r_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = r_timeout;
`else
  assign w_tmo_fire  = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) begin
          w_state_next = cmd_write ? S_WRITE : S_RADDR;
        end
      end
      S_WRITE: begin
        if (w_aw_all && w_w_all) w_state_next = S_WRESP;
        else if (w_tmo_fire)     w_state_next = S_RESP;
      end
      S_WRESP: begin
        if (m_axi_bvalid)    w_state_next = S_RESP;
        else if (w_tmo_fire) w_state_next = S_RESP;
      end
      S_RADDR: begin
        if (m_axi_arready)   w_state_next = S_RDATA;
        else if (w_tmo_fire) w_state_next = S_RESP;
      end
      S_RDATA: begin
        if (m_axi_rvalid)    w_state_next = S_RESP;
        else if (w_tmo_fire) w_state_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only
  always_comb begin
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (r_state)
      S_IDLE:  cmd_ready = 1'b1;
      S_WRITE: begin
        m_axi_awvalid = !r_aw_done;
        m_axi_wvalid  = !r_w_done;
      end
      S_WRESP: m_axi_bready  = 1'b1;
      S_RADDR: m_axi_arvalid = 1'b1;
      S_RDATA: m_axi_rready  = 1'b1;
      S_RESP:  rsp_valid     = 1'b1;
      default: ;
    endcase
  end

  // Command payload, per-channel done flags and captured response
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if ((r_state == S_WRESP) && m_axi_bvalid) begin
        r_resp  <= m_axi_bresp;
        r_rdata <= '0;
      end
      if ((r_state == S_RDATA) && m_axi_rvalid) begin
        r_resp  <= m_axi_rresp;
        r_rdata <= m_axi_rdata;
      end
      if (w_tmo_fire) begin
        r_resp  <= 2'b10;
        r_rdata <= '0;
      end
    end
  end

  assign m_axi_awaddr = r_addr;
  assign m_axi_araddr = r_addr;
  assign m_axi_wdata  = r_wdata;
  assign m_axi_wstrb  = r_wstrb;
  assign rsp_rdata    = r_rdata;
  assign rsp_resp     = r_resp;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: a programmable-latency slave,
// a transaction-level reference model checked every cycle, and directed
// plus randomized commands.
module tb_axi_lite_master;
  localparam int TMO = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [31:0] m_axi_rdata = '0;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [3:0]  m_axi_wstrb;

  axi_lite_master #(.C_ADDR_WIDTH(32), .C_TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial forever #5 aclk = ~aclk;

  int cyc = 0;
  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave response rule: word 2 answers SLVERR, word 15 DECERR, others OKAY
  function automatic logic [1:0] resp_rule(input logic [31:0] a);
    if (a[5:2] == 4'd2)  return 2'b10;
    if (a[5:2] == 4'd15) return 2'b11;
    return 2'b00;
  endfunction

  // ---------------- slave with programmable wait states ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit w_after_aw = 1'b0;

  logic [31:0] s_mem [16];
  initial begin
    bit          rst, awv, wv, arv, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit          s_aw_got, s_w_got, s_ar_got;
    logic [31:0] s_awaddr, s_wdata, s_araddr, c_awaddr, c_wdata, c_araddr;
    logic [3:0]  s_wstrb, c_wstrb;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_wstrb = '0;
    for (int i = 0; i < 16; i++) s_mem[i] = 32'h1111_1111 * i;
    forever begin
      @(negedge aclk);
      rst   = !aresetn;
      awv   = m_axi_awvalid;
      wv    = m_axi_wvalid;
      arv   = m_axi_arvalid;
      aw_hs = m_axi_awvalid && m_axi_awready;
      w_hs  = m_axi_wvalid && m_axi_wready;
      b_hs  = m_axi_bvalid && m_axi_bready;
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      c_awaddr = m_axi_awaddr; c_wdata = m_axi_wdata; c_wstrb = m_axi_wstrb;
      c_araddr = m_axi_araddr;
      @(posedge aclk);
      #1;
      if (rst) begin
        s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
      end else begin
        if (aw_hs) begin s_aw_got = 1; s_awaddr = c_awaddr; end
        if (w_hs)  begin s_w_got = 1; s_wdata = c_wdata; s_wstrb = c_wstrb; end
        if (ar_hs) begin s_ar_got = 1; s_araddr = c_araddr; end
        aw_cnt = (awv && !aw_hs) ? aw_cnt + 1 : 0;
        w_cnt  = (wv && !w_hs) ? w_cnt + 1 : 0;
        ar_cnt = (arv && !ar_hs) ? ar_cnt + 1 : 0;
        if (b_hs) begin
          if (m_axi_bresp == 2'b00)
            for (int b = 0; b < 4; b++)
              if (s_wstrb[b]) s_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
          m_axi_bvalid = 0; s_aw_got = 0; s_w_got = 0; b_cnt = 0;
        end else if (s_aw_got && s_w_got && !m_axi_bvalid) begin
          if (b_cnt >= b_dly) begin
            m_axi_bvalid = 1; m_axi_bresp = resp_rule(s_awaddr);
          end else b_cnt++;
        end
        if (r_hs) begin
          m_axi_rvalid = 0; s_ar_got = 0; r_cnt = 0;
        end else if (s_ar_got && !m_axi_rvalid) begin
          if (r_cnt >= r_dly) begin
            m_axi_rvalid = 1; m_axi_rdata = s_mem[s_araddr[5:2]];
            m_axi_rresp = resp_rule(s_araddr);
          end else r_cnt++;
        end
      end
      m_axi_awready = m_axi_awvalid && !s_aw_got && (aw_cnt >= aw_dly);
      m_axi_wready  = m_axi_wvalid && !s_w_got && (w_cnt >= w_dly) && (!w_after_aw || s_aw_got);
      m_axi_arready = m_axi_arvalid && !s_ar_got && (ar_cnt >= ar_dly);
    end
  end

  // ---------------- transaction-level reference model + compare ----------------
  int n_bhs = 0;
  int n_txn = 0;
  initial begin
    bit          armed, busy, is_wr, aw_seen, w_seen, ar_seen, rp, e_tmo, adv;
    bit          x_act;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_resp;
    logic [31:0] r_mem [16];
    int          tcnt;
    armed = 0; busy = 0; is_wr = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; rp = 0;
    e_tmo = 0; tcnt = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rdata = '0; e_resp = '0;
    for (int i = 0; i < 16; i++) r_mem[i] = 32'h1111_1111 * i;
    forever begin
      @(negedge aclk);
      if (armed) begin
        x_act = busy && !rp;
        chk("cmd_ready", cmd_ready, !busy);
        chk("rsp_valid", rsp_valid, busy && rp);
        chk("awvalid", m_axi_awvalid, x_act && is_wr && !aw_seen);
        chk("wvalid", m_axi_wvalid, x_act && is_wr && !w_seen);
        chk("bready", m_axi_bready, x_act && is_wr && aw_seen && w_seen);
        chk("arvalid", m_axi_arvalid, x_act && !is_wr && !ar_seen);
        chk("rready", m_axi_rready, x_act && !is_wr && ar_seen);
        chk("rsp_timeout", rsp_timeout, e_tmo);
        if (x_act && is_wr && !aw_seen) chk("awaddr", m_axi_awaddr, e_addr);
        if (x_act && is_wr && !w_seen) begin
          chk("wdata", m_axi_wdata, e_wdata);
          chk("wstrb", m_axi_wstrb, e_wstrb);
        end
        if (x_act && !is_wr && !ar_seen) chk("araddr", m_axi_araddr, e_addr);
        if (busy && rp) begin
          chk("rsp_rdata", rsp_rdata, e_rdata);
          chk("rsp_resp", rsp_resp, e_resp);
        end
      end
      // advance the model to what the next cycle must show
      if (!aresetn) begin
        armed = 1; busy = 0; rp = 0; e_tmo = 0; aw_seen = 0; w_seen = 0; ar_seen = 0;
      end else if (armed) begin
        if (!busy) begin
          if (cmd_valid) begin
            busy = 1; is_wr = cmd_write; e_addr = cmd_addr; e_wdata = cmd_wdata;
            e_wstrb = cmd_wstrb; aw_seen = 0; w_seen = 0; ar_seen = 0; rp = 0;
            e_tmo = 0; tcnt = 0;
          end
        end else if (rp) begin
          if (rsp_ready) begin
            busy = 0; rp = 0; n_txn++;
            $display("txn %0d: %s addr=%08h rdata=%08h resp=%0d timeout=%0b", n_txn,
                     is_wr ? "WR" : "RD", e_addr, e_rdata, e_resp, e_tmo);
          end
        end else begin
          adv = 0;
          if (is_wr) begin
            if (aw_seen && w_seen) begin
              if (m_axi_bvalid) begin
                adv = 1; rp = 1; e_resp = resp_rule(e_addr); e_rdata = '0; n_bhs++;
                if (e_resp == 2'b00)
                  for (int b = 0; b < 4; b++)
                    if (e_wstrb[b]) r_mem[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
              end
            end else begin
              if (!aw_seen && m_axi_awready) aw_seen = 1;
              if (!w_seen && m_axi_wready) w_seen = 1;
              if (aw_seen && w_seen) adv = 1;
            end
          end else begin
            if (!ar_seen) begin
              if (m_axi_arready) begin ar_seen = 1; adv = 1; end
            end else if (m_axi_rvalid) begin
              adv = 1; rp = 1; e_rdata = r_mem[e_addr[5:2]]; e_resp = resp_rule(e_addr);
            end
          end
`ifdef AXIL_MASTER_TIMEOUT_EN
          if (adv) tcnt = 0;
          else if (tcnt == TMO - 1) begin
            rp = 1; e_tmo = 1; e_resp = 2'b10; e_rdata = '0;
          end else tcnt++;
`else
          if (adv) tcnt = 0;
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_slave(input int aw, input int w, input int b, input int ar,
                           input int r, input bit wa);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r; w_after_aw = wa;
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int hold,
                        output logic [31:0] rdata, output logic [1:0] resp,
                        output bit tmo, output int lat);
    int n;
    int c0;
    bit ok;
    rdata = '0; resp = '0; tmo = 0; lat = -1;
    @(posedge aclk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    n = 0; ok = 0;
    while (!ok && n < 100) begin
      @(negedge aclk);
      if (cmd_ready) ok = 1; else n++;
    end
    c0 = cyc;
    @(posedge aclk); #1;
    cmd_valid = 0;
    if (!ok) begin
      chk("cmd_accept_wait", 0, 1);
      return;
    end
    rsp_ready = (hold == 0);
    n = 0; ok = 0;
    while (!ok && n < 200) begin
      @(negedge aclk);
      if (rsp_valid) ok = 1; else n++;
    end
    if (!ok) begin
      chk("rsp_valid_wait", 0, 1);
      rsp_ready = 0;
      return;
    end
    lat = cyc - c0; rdata = rsp_rdata; resp = rsp_resp; tmo = rsp_timeout;
    if (hold > 0) begin
      repeat (hold) @(posedge aclk);
      #1 rsp_ready = 1;
    end
    @(posedge aclk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    bit          to;
    int          lat, b0;
    logic [31:0] a, d;
    logic [3:0]  s;

    // reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    @(posedge aclk); #1 aresetn = 1;

    // write with wready only after AW
    set_slave(0, 0, 0, 0, 0, 1);
    b0 = n_bhs;
    do_cmd(1, 32'h00, 32'h5, 4'hF, 0, rd, rs, to, lat);
    chk("wr0_resp", rs, 2'b00);
    chk("wr0_rdata", rd, 0);
    chk("wr0_lat", lat, 4);
    chk("wr0_bcount", n_bhs - b0, 1);
    set_slave(0, 0, 0, 0, 0, 0);
    do_cmd(0, 32'h00, 0, 0, 0, rd, rs, to, lat);
    chk("rd0_rdata", rd, 32'h5);
    chk("rd0_lat", lat, 3);

    // zero-wait write, AW and W in the same cycle
    b0 = n_bhs;
    do_cmd(1, 32'h04, 32'hA, 4'hF, 0, rd, rs, to, lat);
    chk("wr4_lat", lat, 3);
    chk("wr4_bcount", n_bhs - b0, 1);

    // read with 3 waits on arready and 2 on rvalid
    set_slave(0, 0, 0, 3, 2, 0);
    do_cmd(0, 32'h04, 0, 0, 0, rd, rs, to, lat);
    chk("rd4_rdata", rd, 32'h0000_000A);
    chk("rd4_resp", rs, 2'b00);
    chk("rd4_lat", lat, 8);

    // W accepted before AW, partial strobes
    set_slave(3, 0, 0, 0, 0, 0);
    b0 = n_bhs;
    do_cmd(1, 32'h0C, 32'h1234_5678, 4'h3, 0, rd, rs, to, lat);
    chk("wrC_lat", lat, 6);
    chk("wrC_bcount", n_bhs - b0, 1);
    set_slave(0, 0, 0, 0, 0, 0);
    do_cmd(0, 32'h0C, 0, 0, 0, rd, rs, to, lat);
    chk("rdC_rdata", rd, 32'h3333_5678);

    // SLVERR read passes data through; response held for 5 cycles
    do_cmd(0, 32'h08, 0, 0, 5, rd, rs, to, lat);
    chk("rd8_resp", rs, 2'b10);
    chk("rd8_rdata", rd, 32'h2222_2222);
    do_cmd(1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0, rd, rs, to, lat);
    chk("wr8_resp", rs, 2'b10);
    do_cmd(0, 32'h3C, 0, 0, 0, rd, rs, to, lat);
    chk("rd3C_resp", rs, 2'b11);
    chk("rd3C_rdata", rd, 32'hFFFF_FFFF);

    // reset while awvalid is high
    set_slave(8, 8, 0, 0, 0, 0);
    @(posedge aclk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
    @(posedge aclk); #1 cmd_valid = 0;
    @(posedge aclk); #1 aresetn = 0;
    @(negedge aclk);
    chk("prerst_awvalid", m_axi_awvalid, 1);
    @(posedge aclk); #1 aresetn = 1;
    @(negedge aclk);
    chk("postrst_cmd_ready", cmd_ready, 1);
    chk("postrst_awvalid", m_axi_awvalid, 0);
    chk("postrst_wvalid", m_axi_wvalid, 0);
    chk("postrst_rsp_valid", rsp_valid, 0);
    set_slave(0, 0, 0, 0, 0, 0);
    do_cmd(0, 32'h10, 0, 0, 0, rd, rs, to, lat);
    chk("rd10_rdata", rd, 32'h4444_4444);
    chk("rd10_lat", lat, 3);

    // randomized traffic, checked by the model
    for (int i = 0; i < 60; i++) begin
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      do_cmd(1'($urandom_range(0, 1)), a, d, s, $urandom_range(0, 2), rd, rs, to, lat);
      chk("rnd_min_lat", lat >= 3, 1);
    end

`ifdef AXIL_MASTER_TIMEOUT_EN
    // slave never accepts AR: watchdog aborts after TMO cycles
    set_slave(0, 0, 0, 1000, 0, 0);
    do_cmd(0, 32'h10, 0, 0, 0, rd, rs, to, lat);
    chk("tmo_flag", to, 1);
    chk("tmo_resp", rs, 2'b10);
    chk("tmo_rdata", rd, 0);
    chk("tmo_lat", lat, TMO + 1);
    set_slave(0, 0, 0, 0, 0, 0);
    do_cmd(0, 32'h00, 0, 0, 0, rd, rs, to, lat);
    chk("post_tmo_flag", to, 0);
`endif

    repeat (3) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-lite initiator. Converts one user command (read or write) into a complete AXI4-lite transaction and returns the response to the user.
- Sits between local control logic, such as a sequencer or test driver, and any AXI4-lite slave in the design, for example the shift-register control slave.
- One transaction in flight at a time; no bursts.

Parameters:
- C_ADDR_WIDTH, 32, width of cmd_addr and m_axi_awaddr/m_axi_araddr.
- C_TIMEOUT_CYCLES, 255, watchdog limit in aclk cycles. Used only when AXIL_MASTER_TIMEOUT_EN is defined.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle, command accepted on cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  C_ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  user accepts response
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  BRESP or RRESP as returned by the slave
- rsp_timeout  out  1  transaction aborted by watchdog
- m_axi_awaddr  out  C_ADDR_WIDTH, m_axi_awvalid out 1, m_axi_awready in 1
- m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1
- m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1
- m_axi_araddr out C_ADDR_WIDTH, m_axi_arvalid out 1, m_axi_arready in 1
- m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1

Behaviour:
- Reset: aresetn, synchronous, active-low; clock aclk.
  - All valid/ready outputs are 0 except cmd_ready=1.
  - Address, data, response and rsp_timeout registers are 0.
  - FSM is in IDLE.
  - Reset mid-transaction abandons it immediately; no response is produced.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake, latch addr/wdata/wstrb/write.
  - Next state is WRITE (cmd_write=1) or RADDR (cmd_write=0).
- WRITE:
  - awvalid and wvalid both rise in the cycle after the cmd handshake.
  - Each is held with stable payload until its own handshake, independently of the other.
  - Per-channel "done" flags track acceptance.
  - When both are done, go to WRESP. This applies whether they complete in the same cycle or in either order; it must work with slaves that raise wready only after AW.
  - A valid never deasserts before its handshake.
- WRESP: bready=1. On bvalid, latch bresp into rsp_resp, set rsp_rdata=0, go to RESP.
- RADDR: arvalid=1, araddr stable. On arready, go to RDATA.
- RDATA: rready=1. On rvalid, latch rdata and rresp, go to RESP.
- RESP:
  - rsp_valid=1, outputs stable.
  - On rsp_ready, go to IDLE.
  - cmd_ready stays 0 until back in IDLE, so a new command cannot be accepted in the same cycle as the response handshake.
- bready and rready are asserted only in their respective states.
- Slave responses arriving outside those states are ignored.
- SLVERR/DECERR values are passed through unmodified and do not alter the flow.
- Minimum latency, cmd handshake at cycle 0 with a zero-wait slave:
  - Write: AW and W accepted at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - Read: AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.

Optional Feature:
- Macro: AXIL_MASTER_TIMEOUT_EN.
- Defined:
  - A cycle counter resets on every state change and increments in WRITE, WRESP, RADDR and RDATA.
  - When the count reaches C_TIMEOUT_CYCLES, all AXI valid/ready outputs drop and the FSM goes to RESP with rsp_timeout=1, rsp_resp=2'b10 (SLVERR) and rsp_rdata=0.
  - rsp_timeout clears on the next cmd handshake.
- Not defined: no counter; rsp_timeout is tied to 0; the master waits indefinitely.

Test Plan:
- Write addr 0x00, wdata 0x5, wstrb 0xF, slave with wready only after AW -> awvalid before wvalid acceptance; rsp_valid with rsp_resp=00, rsp_rdata=0; slave register reads back 0x5.
- Read addr 0x04 with slave returning rdata=0xA after 3 wait cycles on arready and 2 on rvalid -> araddr stable throughout; rsp_rdata=0x0000000A, rsp_resp=00.
- Write where the slave accepts W before AW, and a second write with both in the same cycle -> single B handshake each; WRESP entered exactly once; no duplicate valids.
- Slave returns RRESP=2'b10 for addr 0x08 -> rsp_resp=10 with rdata passed through; user holds rsp_ready=0 for 5 cycles -> rsp_valid and payload stable, cmd_ready=0.
- aresetn low for 1 cycle while awvalid=1 -> next cycle all valids are 0, cmd_ready=1, no rsp_valid; a following read completes normally.
- With AXIL_MASTER_TIMEOUT_EN and C_TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops after 16 cycles; rsp_valid=1, rsp_timeout=1, rsp_resp=10.
